// File: rtl/image_downscale_2x2.sv
// image_downscale_2x2: streaming 2x2 box-filter downscaler (half width, half height, per-channel average).
// Define DOWNSCALE_ROUND_EN for round-half-up averaging; the default build truncates.
module image_downscale_2x2 #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       horizontal_clock,
    input  logic       horizontal_reset,
    input  logic       horizontal_sync,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       out_sync,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int AW = WIDTH > 2 ? $clog2(WIDTH / 2) : 1;

    typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [23:0]    pair;
    logic [26:0]    line_buf [WIDTH/2];
    logic [AW-1:0]  idx;
    logic [23:0]    pix;
    logic [26:0]    sum;
    logic [26:0]    rd;
    logic [29:0]    total;
    logic [23:0]    avg;
    logic           accept;
    logic           last_col;

    function automatic logic [7:0] scale(input logic [9:0] t);
`ifdef DOWNSCALE_ROUND_EN
        return 8'((t + 10'd2) >> 2);
`else
        return 8'(t >> 2);
`endif
    endfunction

    assign pix      = {r, g, b};
    assign idx      = AW'(col >> 1);
    assign rd       = line_buf[idx];
    assign accept   = horizontal_sync && state != DONE;
    assign last_col = col == CW'(WIDTH - 1);

    // Channel i=2 is red, i=0 is blue, matching the {r,g,b} packing.
    always_comb begin
        sum   = '0;
        total = '0;
        avg   = '0;
        for (int i = 0; i < 3; i++) begin
            sum[9*i+:9]    = {1'b0, pair[8*i+:8]} + {1'b0, pix[8*i+:8]};
            total[10*i+:10] = {1'b0, rd[9*i+:9]} + {1'b0, sum[9*i+:9]};
            avg[8*i+:8]    = scale(total[10*i+:10]);
        end
    end

    // Combinational read: every entry is written during the even row before the odd row reads it.
    always_ff @(posedge horizontal_clock) begin
        if (accept && state == ROW_EVEN && col[0])
            line_buf[idx] <= sum;
    end

    always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
        if (!horizontal_reset) begin
            state    <= ROW_EVEN;
            col      <= '0;
            row      <= '0;
            pair     <= '0;
            out_sync <= 1'b0;
            out_r    <= '0;
            out_g    <= '0;
            out_b    <= '0;
            done     <= 1'b0;
        end else begin
            out_sync <= 1'b0;
            if (accept) begin
                if (!col[0])
                    pair <= pix;
                if (state == ROW_ODD && col[0]) begin
                    out_sync                <= 1'b1;
                    {out_r, out_g, out_b}   <= avg;
                end
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                    if (state == ROW_EVEN)
                        state <= ROW_ODD;
                    else if (row == RW'(HEIGHT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else
                        state <= ROW_EVEN;
                end else
                    col <= col + 1'b1;
            end
        end
    end
endmodule

// File: doc/image_downscale_2x2.md
# image_downscale_2x2

Streaming 2x2 box-filter downscaler placed between the image reader and the BMP writer. It consumes the reader's row-major pixel stream (sync strobe plus 8-bit R/G/B) and emits a half-width, half-height pixel stream in the same format. Each output pixel is the per-channel average of one 2x2 input block. It asserts `done` once the last output pixel of the frame has been produced.

## Interface
- `WIDTH`, 768: input pixels per row; must be even and at least 2.
- `HEIGHT`, 512: input rows per frame; must be even and at least 2.
- `horizontal_clock`  in  1  system clock; all logic is on the rising edge.
- `horizontal_reset`  in  1  reset; asynchronous, active-low.
- `horizontal_sync`  in  1  input valid; high means `r`/`g`/`b` carry one pixel this cycle.
- `r`, `g`, `b`  in  8 each  input pixel channels.
- `out_sync`  out  1  output valid; high for exactly one cycle per output pixel.
- `out_r`, `out_g`, `out_b`  out  8 each  output pixel channels; meaningful only while `out_sync` is high.
- `done`  out  1  frame complete; sticky until reset.

## Operation
- Counters:
  - `col` counts 0..WIDTH-1.
  - `row` counts 0..HEIGHT-1.
  - Both advance only on cycles where `horizontal_sync` is high. There is no backpressure, so the upstream stage may insert idle gaps freely.
- Pair register: on even `col`, latch the pixel. On odd `col`, form a 9-bit per-channel pair sum: latched pixel plus current pixel.
- States:
  - ROW_EVEN:
    - On each odd `col`, write the pair sum (27 bits) to line buffer entry `col>>1`.
    - The buffer holds WIDTH/2 entries.
    - No output is produced in this state.
  - ROW_ODD:
    - On each odd `col`, total = buffer[`col>>1`] + current pair sum. Total is 10 bits per channel.
    - Output = total >> 2, with rounding per Configuration.
    - `out_sync` pulses with the result.
  - DONE:
    - `done` is high.
    - `horizontal_sync` is ignored; no further writes or outputs occur.
- Transitions:
  - ROW_EVEN -> ROW_ODD when `col` = WIDTH-1 with valid input.
  - ROW_ODD -> ROW_EVEN when `col` = WIDTH-1 and `row` < HEIGHT-1.
  - ROW_ODD -> DONE when `col` = WIDTH-1 and `row` = HEIGHT-1.
- Wrap: `col` returns to 0 after WIDTH-1, and `row` increments at that point.
- Frame size: exactly (WIDTH/2)*(HEIGHT/2) output pulses per frame.
- Arithmetic: no saturation is needed. Worst case is (1020+2)>>2 = 255.
- Line buffer: never reset. Every entry is written in ROW_EVEN before it is read in ROW_ODD.

## Timing
- Reset values:
  - `out_sync` = 0.
  - `out_r`/`out_g`/`out_b` = 0.
  - `done` = 0.
  - `col` = `row` = 0; state = ROW_EVEN; pair register = 0.
- Latency:
  - Output registers update on the edge that samples the second pixel of the odd-row pair.
  - `out_sync` is therefore high in the cycle after that pixel is presented (1-cycle latency).
- Output hold: `out_r`/`out_g`/`out_b` hold their last value while `out_sync` is low.
- `done` timing:
  - `done` rises on the same edge that raises the final `out_sync`.
  - Both are visible together in that cycle.
  - `out_sync` then drops; `done` stays high.
- Back-to-back input: one pixel per cycle gives an output every 2 cycles during odd rows.
- Line buffer read: the buffer read for the odd row must have the value available by the odd-`col` cycle. Use a combinational or registered read issued on the even-`col` cycle; it must be valid even with a one-cycle gap.
- Reset mid-frame: asynchronously returns everything to reset values. The next valid pixel is treated as pixel (0,0).

## Configuration
- `DOWNSCALE_ROUND_EN` defined: output = (total + 2) >> 2, i.e. round-half-up.
- `DOWNSCALE_ROUND_EN` undefined: output = total >> 2, i.e. truncation. Saves the adder stage.

## Test plan
- WIDTH=4, HEIGHT=4, all pixels R=G=B=100, continuous valid -> 4 outputs, all channels 100. `done` is high with the 4th `out_sync` and remains high.
- 2x2 block with R values 0,1,1,1 -> `out_r`=1 with `DOWNSCALE_ROUND_EN`, 0 without. Block 255,255,255,255 -> 255 in both builds.
- Distinct R per 2x2 block on a 4x4 image: top-left block (10,20,30,40) -> 25; top-right block (0,0,0,4) -> 1 -> outputs appear in raster order 25, 1, ...
- Same 4x4 image with `horizontal_sync` low every other cycle -> identical output values and count. `out_sync` is never high two cycles in a row.
- Reset asserted mid-row-1 of a 4x4 frame, then a full frame replayed -> `out_*`/`done` read 0 during reset. Exactly 4 correct outputs follow, none stale.
- Extra valid pixels after `done` -> no `out_sync` pulses; `done` stays 1.
